// File: rtl/data_memory_lsu.sv
// Byte-addressable MEM-stage data memory: byte/half/word loads and stores with
// extension and misalignment rejection, a post-reset clear sweep and a debug read port.
module data_memory_lsu #(
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  i_reset,
    input  logic                  i_read,
    input  logic                  i_write,
    input  logic [1:0]            i_size,
    input  logic                  i_unsigned,
    input  logic [ADDR_WIDTH+1:0] i_address,
    input  logic [31:0]           i_data,
    output logic [31:0]           o_data,
    output logic                  o_valid,
    output logic                  o_misaligned,
    output logic                  o_busy,
    input  logic [ADDR_WIDTH-1:0] i_debug_addr,
    output logic [31:0]           o_debug_data,
    output logic                  o_fsm_state
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clr_cnt_q;
    logic [31:0]             mem [DEPTH];

    logic [ADDR_WIDTH-1:0]   word_idx;
    logic [1:0]              lane;
    logic                    idle, misaligned, do_write, do_read, rejected;
    logic [3:0]              byte_en;
    logic [31:0]             wdata, rword, load_val;
    logic [7:0]              ld_byte;
    logic [15:0]             ld_half;

    assign word_idx    = i_address[ADDR_WIDTH+1:2];
    assign lane        = i_address[1:0];
    assign idle        = (state_q == ST_IDLE);
    assign o_busy      = (state_q == ST_CLEAR);
    assign o_fsm_state = state_q;

    // FSM next state: leave CLEAR once the last word is being zeroed.
    always_comb begin
        state_d = state_q;
        if (state_q == ST_CLEAR && clr_cnt_q == {ADDR_WIDTH{1'b1}}) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_CLEAR) begin
                clr_cnt_q <= clr_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        misaligned = (i_size == 2'b11)
                   || (i_size == 2'b01 && lane[0])
                   || (i_size == 2'b10 && lane != 2'b00);
    end

    // A simultaneous read is dropped in favour of the write.
    assign do_write = idle && i_write && !misaligned && !i_reset;
    assign do_read  = idle && i_read && !i_write;
    assign rejected = idle && (i_read || i_write) && misaligned;

    // Store data is replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        byte_en = 4'b0000;
        wdata   = i_data;
        case (i_size)
            2'b00: begin
                byte_en = 4'b0001 << lane;
                wdata   = {4{i_data[7:0]}};
            end
            2'b01: begin
                byte_en = lane[1] ? 4'b1100 : 4'b0011;
                wdata   = {2{i_data[15:0]}};
            end
            2'b10: byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!i_reset && state_q == ST_CLEAR) begin
            mem[clr_cnt_q] <= '0;
        end else if (do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[word_idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rword   = mem[word_idx];
    assign ld_byte = rword[{lane, 3'b000} +: 8];
    assign ld_half = lane[1] ? rword[31:16] : rword[15:0];

    always_comb begin
        case (i_size)
            2'b00:   load_val = i_unsigned ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   load_val = i_unsigned ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: load_val = rword;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            o_data       <= '0;
            o_valid      <= 1'b0;
            o_misaligned <= 1'b0;
            o_debug_data <= '0;
        end else begin
            o_valid      <= do_read;
            o_misaligned <= rejected;
            o_debug_data <= mem[i_debug_addr];
            if (do_read) begin
                o_data <= misaligned ? 32'h0 : load_val;
            end
        end
    end
endmodule

// File: tb/tb_data_memory_lsu.sv
// Directed bench for data_memory_lsu: clear sweep, lane stores, extended loads,
// misalignment, read/write collision, reset during clear and debug port timing.
module tb_data_memory_lsu;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          i_reset = 1'b1;
    logic          i_read = 1'b0;
    logic          i_write = 1'b0;
    logic [1:0]    i_size = 2'b10;
    logic          i_unsigned = 1'b0;
    logic [AW+1:0] i_address = '0;
    logic [31:0]   i_data = '0;
    logic [31:0]   o_data;
    logic          o_valid;
    logic          o_misaligned;
    logic          o_busy;
    logic [AW-1:0] i_debug_addr = '0;
    logic [31:0]   o_debug_data;
    logic          o_fsm_state;

    int checks = 0;
    int errors = 0;
    int n;

    data_memory_lsu #(.ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .i_reset      (i_reset),
        .i_read       (i_read),
        .i_write      (i_write),
        .i_size       (i_size),
        .i_unsigned   (i_unsigned),
        .i_address    (i_address),
        .i_data       (i_data),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .o_misaligned (o_misaligned),
        .o_busy       (o_busy),
        .i_debug_addr (i_debug_addr),
        .o_debug_data (o_debug_data),
        .o_fsm_state  (o_fsm_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled on the following falling edge.
    task automatic access(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [AW+1:0] addr, input logic [31:0] data);
        i_read = rd; i_write = wr; i_size = sz; i_unsigned = uns;
        i_address = addr; i_data = data;
        @(negedge clk);
        i_read = 1'b0; i_write = 1'b0;
    endtask

    task automatic store(input logic [1:0] sz, input logic [AW+1:0] addr, input logic [31:0] data,
                         input logic exp_mis, input string tag);
        access(1'b0, 1'b1, sz, 1'b0, addr, data);
        check({tag, "_valid"}, {31'h0, o_valid}, 32'h0);
        check({tag, "_mis"}, {31'h0, o_misaligned}, {31'h0, exp_mis});
    endtask

    task automatic load(input logic [1:0] sz, input logic uns, input logic [AW+1:0] addr,
                        input logic [31:0] exp, input logic exp_mis, input string tag);
        access(1'b1, 1'b0, sz, uns, addr, 32'h0);
        check({tag, "_data"}, o_data, exp);
        check({tag, "_valid"}, {31'h0, o_valid}, 32'h1);
        check({tag, "_mis"}, {31'h0, o_misaligned}, {31'h0, exp_mis});
    endtask

    task automatic debug_read(input logic [AW-1:0] a, input logic [31:0] exp, input string tag);
        i_debug_addr = a;
        @(negedge clk);
        check(tag, o_debug_data, exp);
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        @(negedge clk);
        i_reset = 1'b0;
    endtask

    task automatic wait_clear(output int cycles);
        cycles = 0;
        while (o_busy && cycles < 200) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_data", o_data, 32'h0);
        check("rst_valid", {31'h0, o_valid}, 32'h0);
        check("rst_mis", {31'h0, o_misaligned}, 32'h0);
        check("rst_busy", {31'h0, o_busy}, 32'h1);
        check("rst_dbg", o_debug_data, 32'h0);
        i_reset = 1'b0;
        wait_clear(n);
        check("clear_len", n, 32);

        // Word store then load on the next cycle; o_data holds afterwards.
        store(2'b10, 7'h08, 32'hDEADBEEF, 1'b0, "sw08");
        load(2'b10, 1'b0, 7'h08, 32'hDEADBEEF, 1'b0, "lw08");
        @(negedge clk);
        check("lw08_pulse", {31'h0, o_valid}, 32'h0);
        check("lw08_hold", o_data, 32'hDEADBEEF);

        // Byte/half lanes and extension.
        store(2'b10, 7'h0C, 32'h11223380, 1'b0, "sw0c");
        store(2'b00, 7'h0E, 32'h000000AA, 1'b0, "sb0e");
        debug_read(5'd3, 32'h11AA3380, "dbg_w3");
        load(2'b00, 1'b0, 7'h0C, 32'hFFFFFF80, 1'b0, "lb0c");
        load(2'b00, 1'b1, 7'h0C, 32'h00000080, 1'b0, "lbu0c");
        load(2'b01, 1'b0, 7'h0E, 32'h000011AA, 1'b0, "lh0e");
        load(2'b01, 1'b0, 7'h0C, 32'h00003380, 1'b0, "lh0c");
        load(2'b00, 1'b0, 7'h0E, 32'hFFFFFFAA, 1'b0, "lb0e");
        load(2'b10, 1'b1, 7'h0C, 32'h11AA3380, 1'b0, "lw0c_u");
        store(2'b01, 7'h0C, 32'h7777BEEF, 1'b0, "sh0c");
        load(2'b01, 1'b0, 7'h0C, 32'hFFFFBEEF, 1'b0, "lh0c_b");
        load(2'b10, 1'b0, 7'h0C, 32'h11AABEEF, 1'b0, "lw0c_b");

        // Misalignment.
        store(2'b10, 7'h10, 32'h55667788, 1'b0, "sw10");
        store(2'b10, 7'h11, 32'hFFFFFFFF, 1'b1, "sw11");
        debug_read(5'd4, 32'h55667788, "dbg_w4");
        load(2'b01, 1'b0, 7'h13, 32'h0, 1'b1, "lh13");
        @(negedge clk);
        check("mis_pulse", {31'h0, o_misaligned}, 32'h0);
        load(2'b11, 1'b0, 7'h10, 32'h0, 1'b1, "ill10");
        store(2'b01, 7'h11, 32'h0000FFFF, 1'b1, "sh11");
        load(2'b10, 1'b0, 7'h10, 32'h55667788, 1'b0, "lw10");

        // Read and write together: only the store happens.
        access(1'b1, 1'b1, 2'b10, 1'b0, 7'h14, 32'hCAFEF00D);
        check("rw_valid", {31'h0, o_valid}, 32'h0);
        check("rw_mis", {31'h0, o_misaligned}, 32'h0);
        load(2'b10, 1'b0, 7'h14, 32'hCAFEF00D, 1'b0, "lw14");

        // Debug port shows the pre-write value in the cycle of the store.
        i_debug_addr = 5'd6;
        access(1'b0, 1'b1, 2'b10, 1'b0, 7'h18, 32'h0BADF00D);
        check("dbg_prewrite", o_debug_data, 32'h0);
        @(negedge clk);
        check("dbg_postwrite", o_debug_data, 32'h0BADF00D);

        // Reset in IDLE drops the pending load and re-clears the filled array.
        i_read = 1'b1; i_size = 2'b10; i_address = 7'h08; i_reset = 1'b1;
        @(negedge clk);
        i_read = 1'b0; i_reset = 1'b0;
        check("rst_idle_valid", {31'h0, o_valid}, 32'h0);
        check("rst_idle_busy", {31'h0, o_busy}, 32'h1);
        wait_clear(n);
        check("reclear_len", n, 32);
        for (int a = 0; a < 32; a++) begin
            debug_read(a[AW-1:0], 32'h0, $sformatf("clr_w%0d", a));
        end

        // Accesses during CLEAR are ignored; reset at counter 20 restarts the sweep.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            if (i < 10)      access(1'b0, 1'b1, 2'b10, 1'b0, 7'h00, 32'hFFFFFFFF);
            else if (i < 15) access(1'b1, 1'b0, 2'b10, 1'b0, 7'h04, 32'h0);
            else             access(1'b1, 1'b0, 2'b01, 1'b0, 7'h01, 32'h0);
            check($sformatf("clr_ign_valid%0d", i), {31'h0, o_valid}, 32'h0);
            check($sformatf("clr_ign_mis%0d", i), {31'h0, o_misaligned}, 32'h0);
        end
        do_reset();
        wait_clear(n);
        check("midreset_len", n, 32);
        debug_read(5'd0, 32'h0, "dbg_w0_after");
        load(2'b10, 1'b0, 7'h00, 32'h0, 1'b0, "lw00_first");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
